// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// The optional RV_ENC_IMM_CHECK_EN build is consumed by rv_instr_encoder.
package rv_enc_pkg;

   typedef enum logic [2:0] {
      OP_R    = 3'd0,
      OP_I    = 3'd1,
      OP_LW   = 3'd2,
      OP_SW   = 3'd3,
      OP_BR   = 3'd4,
      OP_JAL  = 3'd5,
      OP_JALR = 3'd6,
      OP_HALT = 3'd7
   } op_class_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_HALT   = 7'b0000000;

   localparam logic [31:0] HALT_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENC,
      ST_WRITE,
      ST_HALT_WR,
      ST_DONE
   } state_e;

   typedef struct packed {
      op_class_e   op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic        f7b5;
      logic [20:0] imm;
      logic        last;
   } enc_req_t;

endpackage

// File: rtl/rv_instr_encoder_word_pack.sv
// rv_word_pack: combinational field packer producing one RV32I word and
// a flag raised when the immediate does not fit its encoding.
module rv_word_pack
   import rv_enc_pkg::*;
(
   input  op_class_e   op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        f7b5,
   input  logic [20:0] imm,
   output logic [31:0] word,
   output logic        range_bad
);

   logic s12_bad;
   logic s13_bad;
   logic shift_op;

   assign s12_bad  = !((imm[20:11] == '0) || (imm[20:11] == '1));
   assign s13_bad  = !((imm[20:12] == '0) || (imm[20:12] == '1));
   assign shift_op = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      word      = HALT_WORD;
      range_bad = 1'b0;
      case (op)
         OP_R: word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
         OP_I: begin
            // shifts carry shamt in imm[4:0] and the sra/srai select in bit 30
            if (shift_op) begin
               word      = {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, OPC_IMM};
               range_bad = (imm[20:5] != '0);
            end else begin
               word      = {imm[11:0], rs1, funct3, rd, OPC_IMM};
               range_bad = s12_bad;
            end
         end
         OP_LW: begin
            word      = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            range_bad = s12_bad;
         end
         OP_SW: begin
            word      = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
            range_bad = s12_bad;
         end
         OP_BR: begin
            word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            range_bad = s13_bad || imm[0];
         end
         OP_JAL: begin
            word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            range_bad = imm[0];
         end
         OP_JALR: begin
            word      = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            range_bad = s12_bad;
         end
         default: word = {25'b0, OPC_HALT};
      endcase
   end

endmodule

// File: rtl/rv_instr_encoder.sv
// Packs symbolic requests into RV32I words, streams them to instruction memory
// and always terminates with HALT. Define RV_ENC_IMM_CHECK_EN for err_range.
module rv_instr_encoder
   import rv_enc_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [20:0]       in_imm,
   input  logic              in_last,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err_range,
   output logic              err_full
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_SLOT = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
   logic [ADDR_W:0]   count_q, count_d;
   enc_req_t          req_q, req_d;
   logic [31:0]       mem_data_q, mem_data_d, pack_word;
   logic              mem_valid_q, mem_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              done_q, done_d;
   logic              err_range_q, err_range_d;
   logic              err_full_q, err_full_d;
   logic              range_bad, imm_flag;

   rv_word_pack u_pack (
      .op       (req_q.op),
      .rd       (req_q.rd),
      .rs1      (req_q.rs1),
      .rs2      (req_q.rs2),
      .funct3   (req_q.funct3),
      .f7b5     (req_q.f7b5),
      .imm      (req_q.imm),
      .word     (pack_word),
      .range_bad(range_bad)
   );

`ifdef RV_ENC_IMM_CHECK_EN
   assign imm_flag = range_bad;
`else
   logic unused_range_bad;
   assign unused_range_bad = range_bad;
   assign imm_flag         = 1'b0;
`endif

   assign addr_inc = addr_q + ADDR_W'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      req_d       = req_q;
      mem_data_d  = mem_data_q;
      mem_valid_d = mem_valid_q;
      in_ready_d  = in_ready_q;
      done_d      = done_q;
      err_range_d = err_range_q;
      err_full_d  = err_full_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d      = BASE;
               count_d     = '0;
               err_range_d = 1'b0;
               err_full_d  = 1'b0;
            end
            if (in_valid) begin
               req_d      = '{op: op_class_e'(in_op), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                              funct3: in_funct3, f7b5: in_f7b5, imm: in_imm, last: in_last};
               in_ready_d = 1'b0;
               state_d    = ST_ENC;
            end
         end
         ST_ENC: begin
            mem_data_d  = pack_word;
            err_range_d = err_range_q | imm_flag;
            mem_valid_d = 1'b1;
            state_d     = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_ready) begin
               addr_d  = addr_inc;
               count_d = count_q + 1'b1;
               if (req_q.op == OP_HALT) begin
                  mem_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = ST_DONE;
               end else if (req_q.last || (addr_inc == LAST_SLOT)) begin
                  // the final slot is kept for HALT so the program is always terminated
                  err_full_d = err_full_q | !req_q.last;
                  mem_data_d = HALT_WORD;
                  state_d    = ST_HALT_WR;
               end else begin
                  mem_valid_d = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_HALT_WR: begin
            if (mem_ready) begin
               count_d     = count_q + 1'b1;
               mem_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               addr_d      = BASE;
               count_d     = '0;
               err_range_d = 1'b0;
               err_full_d  = 1'b0;
               done_d      = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= BASE;
         count_q     <= '0;
         req_q       <= '0;
         mem_data_q  <= '0;
         mem_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         done_q      <= 1'b0;
         err_range_q <= 1'b0;
         err_full_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         req_q       <= req_d;
         mem_data_q  <= mem_data_d;
         mem_valid_q <= mem_valid_d;
         in_ready_q  <= in_ready_d;
         done_q      <= done_d;
         err_range_q <= err_range_d;
         err_full_q  <= err_full_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = addr_q;
   assign mem_data  = mem_data_q;
   assign count     = count_q;
   assign done      = done_q;
   assign err_range = err_range_q;
   assign err_full  = err_full_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: directed program cases plus random
// programs, checked against an arithmetic reference encoder.
module tb_rv_instr_encoder;

   localparam int ADDR_W    = 8;
   localparam int BASE_ADDR = 0;
   localparam int DEPTH     = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        in_op = '0;
   logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]        in_funct3 = '0;
   logic              in_f7b5 = 1'b0;
   logic [20:0]       in_imm = '0;
   logic              in_last = 1'b0;
   logic              mem_valid;
   logic              mem_ready = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic [ADDR_W:0]   count;
   logic              done, err_range, err_full;

   always #5 clk = ~clk;

   rv_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .count(count), .done(done), .err_range(err_range), .err_full(err_full)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [ADDR_W+31:0] sb[$];
   int m_addr, m_count;
   bit m_err_range, m_err_full;
   int rdy_mode = 0;  // 0 always ready, 1 random, 2 held low

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2, int f3, int f7, int imm);
      int unsigned u, w;
      u = imm;
      case (op)
         0: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
         1: if (f3 == 1 || f3 == 5)
               w = (f7 << 30) | ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            else
               w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
         2: w = ((u & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
         3: w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((u & 31) << 7) | 'h23;
         4: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                | (f3 << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
         5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
         6: w = ((u & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
         default: w = 0;
      endcase
      return 32'(w);
   endfunction

   function automatic bit ref_bad(int op, int f3, int imm);
      case (op)
         1: if (f3 == 1 || f3 == 5) return (imm < 0 || imm > 31);
            else return (imm < -2048 || imm > 2047);
         2, 3, 6: return (imm < -2048 || imm > 2047);
         4: return (imm < -4096 || imm > 4095 || (imm % 2) != 0);
         5: return ((imm % 2) != 0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int rand_imm(int op, int f3);
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
      case (op)
         1: if (f3 == 1 || f3 == 5) return int'($urandom_range(0, 31));
            else return int'($urandom_range(0, 4095)) - 2048;
         2, 3, 6: return int'($urandom_range(0, 4095)) - 2048;
         4: return (int'($urandom_range(0, 8191)) - 4096) & ~1;
         default: return (int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20)) & ~1;
      endcase
   endfunction

   task automatic model_clear();
      m_addr = BASE_ADDR; m_count = 0; m_err_range = 1'b0; m_err_full = 1'b0;
   endtask

   task automatic send(input int op, input int rd, input int rs1, input int rs2, input int f3,
                       input int f7, input int imm, input bit last, input logic [31:0] exp_word);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
      in_funct3 = 3'(f3); in_f7b5 = f7[0]; in_imm = 21'(imm); in_last = last;
      while (!in_ready && waited < 500) begin @(negedge clk); waited++; end
      chk("accept", 64'(in_ready), 64'd1);
      if (in_ready) begin
         @(posedge clk);
         sb.push_back({ADDR_W'(m_addr), exp_word});
         m_addr = (m_addr + 1) % DEPTH; m_count++;
`ifdef RV_ENC_IMM_CHECK_EN
         if (ref_bad(op, f3, imm)) m_err_range = 1'b1;
`endif
         if (op != 7 && (last || m_addr == DEPTH - 1)) begin
            if (!last) m_err_full = 1'b1;
            sb.push_back({ADDR_W'(m_addr), 32'h0});
            m_count++;
         end
      end
      #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      model_clear();
      chk("start_done", 64'(done), 64'd0);
      chk("start_count", 64'(count), 64'd0);
      chk("start_errs", 64'({err_range, err_full}), 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 3000) begin @(negedge clk); n++; end
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_count"}, 64'(count), 64'(m_count));
      chk({tag, "_err_full"}, 64'(err_full), 64'(m_err_full));
      chk({tag, "_err_range"}, 64'(err_range), 64'(m_err_range));
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      chk({tag, "_idle_bus"}, 64'(mem_valid), 64'd0);
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: mem_ready = 1'b1;
         1: mem_ready = 1'($urandom_range(0, 1));
         default: mem_ready = 1'b0;
      endcase
   end

   // monitor: pops on each write handshake and checks stall stability
   initial begin
      logic [ADDR_W+31:0] e;
      logic [ADDR_W-1:0]  h_addr;
      logic [31:0]        h_data;
      bit                 stall;
      stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("stall_valid", 64'(mem_valid), 64'd1);
               chk("stall_addr", 64'(mem_addr), 64'(h_addr));
               chk("stall_data", 64'(mem_data), 64'(h_data));
            end
            if (mem_valid && mem_ready) begin
               chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("wr_addr", 64'(mem_addr), 64'(e[ADDR_W+31:32]));
                  chk("wr_data", 64'(mem_data), 64'(e[31:0]));
               end
               stall = 1'b0;
            end else if (mem_valid) begin
               stall = 1'b1; h_addr = mem_addr; h_data = mem_data;
            end else begin
               stall = 1'b0;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_flags", 64'({done, err_range, err_full}), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'(BASE_ADDR));
      chk("rst_data", 64'(mem_data), 64'd0);
      #2 reset_n = 1'b1;

      // single addi with last, plus accept-to-write latency
      rdy_mode = 0;
      send(1, 1, 0, 0, 0, 0, 5, 1'b1, 32'h00500093);
      @(negedge clk); chk("lat_enc", 64'(mem_valid), 64'd0);
      @(negedge clk); chk("lat_write", 64'(mem_valid), 64'd1);
      wait_done("addi");

      // add/sub with a 5-cycle memory stall on the second word
      do_start();
      send(0, 3, 1, 2, 0, 0, 0, 1'b0, 32'h002081B3);
      send(0, 3, 1, 2, 0, 1, 0, 1'b0, 32'h402081B3);
      rdy_mode = 2;
      n = 0;
      while (!mem_valid && n < 10) begin @(negedge clk); n++; end
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", 64'(mem_valid), 64'd1);
         chk("hold_addr", 64'(mem_addr), 64'd1);
         chk("hold_data", 64'(mem_data), 64'h402081B3);
      end
      rdy_mode = 0;
      send(7, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
      wait_done("rtype");

      do_start();
      send(3, 0, 1, 2, 0, 0, 8, 1'b0, 32'h0020A423);
      send(4, 0, 1, 2, 0, 0, -4, 1'b0, 32'hFE208EE3);
      send(5, 1, 0, 0, 0, 0, 8, 1'b1, 32'h008000EF);
      wait_done("sw_br_jal");

      // out-of-range immediate is still written truncated
      do_start();
      send(1, 1, 0, 0, 0, 0, 2048, 1'b1, 32'h80000093);
      wait_done("imm_range");

      rdy_mode = 1;
      for (int p = 0; p < 6; p++) begin
         int len;
         bit term_last;
         do_start();
         len = int'($urandom_range(1, 15));
         term_last = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) begin
            int op, rd, rs1, rs2, f3, f7, imm;
            bit lst;
            op = int'($urandom_range(0, 6)); rd = int'($urandom_range(0, 31));
            rs1 = int'($urandom_range(0, 31)); rs2 = int'($urandom_range(0, 31));
            f3 = int'($urandom_range(0, 7)); f7 = int'($urandom_range(0, 1));
            imm = rand_imm(op, f3);
            lst = (i == len - 1) && term_last;
            send(op, rd, rs1, rs2, f3, f7, imm, lst, ref_word(op, rd, rs1, rs2, f3, f7, imm));
         end
         if (!term_last) send(7, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
         wait_done("random");
      end

      // capacity: the last slot is taken by HALT and further requests stall
      rdy_mode = 0;
      do_start();
      for (int i = 0; i < DEPTH - 1; i++)
         send(1, i % 32, 2, 0, 0, 0, i % 100, 1'b0, ref_word(1, i % 32, 2, 0, 0, 0, i % 100));
      wait_done("full");
      @(negedge clk); in_valid = 1'b1; in_op = 3'd1;
      repeat (8) begin
         @(negedge clk);
         chk("full_no_accept", 64'(in_ready), 64'd0);
         chk("full_no_write", 64'(mem_valid), 64'd0);
      end
      in_valid = 1'b0;

      // asynchronous reset in the middle of a stalled write
      do_start();
      rdy_mode = 2;
      send(1, 4, 0, 0, 0, 0, 1, 1'b0, 32'h00100213);
      n = 0;
      while (!mem_valid && n < 10) begin @(negedge clk); n++; end
      chk("pre_rst_valid", 64'(mem_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_mem_valid", 64'(mem_valid), 64'd0);
      chk("arst_addr", 64'(mem_addr), 64'(BASE_ADDR));
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      model_clear();
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      do_start();
      send(2, 5, 6, 0, 0, 0, -8, 1'b1, 32'hFF832283);
      wait_done("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
